// File: rtl/axi_mem_pkg.sv
// Shared constants for the AXI4 memory slave: burst encodings, response codes
// and the write/read FSM state encodings.
package axi_mem_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_DATA = 2'd1;
    localparam w_state_t W_RESP = 2'd2;

    typedef logic [1:0] r_state_t;
    localparam r_state_t R_IDLE = 2'd0;
    localparam r_state_t R_WAIT = 2'd1;
    localparam r_state_t R_DATA = 2'd2;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational burst address stepper: next beat address, memory word index
// and a legality/range error flag for the current beat.
module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int MEM_DEPTH = 65536,
    parameter int IDX_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic [IDX_W-1:0]  word_idx,
    output logic              err
);
    localparam int WORD_SHIFT = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] word_off;
    logic              size_err;
    logic              burst_err;
    logic              range_err;

    // The WRAP window is (len+1)*bytes and aligned to its own size, so only
    // the bits under the mask advance while the upper bits stay put.
    always_comb begin
        step      = ADDR_W'(1) << size;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        word_off  = (addr - BASE_ADDR) >> WORD_SHIFT;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + step;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     next_addr = addr;
        endcase
        size_err  = {5'd0, size} > 8'(WORD_SHIFT);
        burst_err = (burst == 2'b11) ||
                    ((burst == BURST_WRAP) &&
                     !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        range_err = (addr < BASE_ADDR) || (word_off >= ADDR_W'(MEM_DEPTH));
        err       = size_err || burst_err || range_err;
        word_idx  = word_off[IDX_W-1:0];
    end
endmodule

// File: rtl/axi_full_mem_slave.sv
// AXI4-full slave memory model with independent write and read FSMs,
// programmable read latency and optional LFSR-driven ready backpressure.
module axi_full_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BASE_ADDR = 32'h1000_0000,
    parameter int MEM_DEPTH          = 65536,
    parameter int RD_LATENCY         = 2,
    parameter bit BP_EN              = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int ID_W   = C_S_AXI_ID_WIDTH;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]        aw_len_q, aw_len_d, w_beat_q, w_beat_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic              w_err_q, w_err_d;

    r_state_t          r_state_q, r_state_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]        ar_len_q, ar_len_d, r_beat_q, r_beat_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [3:0]        r_wait_q, r_wait_d;

    logic [15:0]       lfsr_q, lfsr_d;

    logic [ADDR_W-1:0] w_next_addr, r_next_addr;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              w_gen_err, r_gen_err, w_beat_err, w_hs, r_hs;
    logic              bp_aw, bp_w, bp_ar;
    logic              unused_inputs;

    axi_burst_addr_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .IDX_W(IDX_W), .BASE_ADDR(MEM_BASE_ADDR)
    ) u_wr_gen (
        .addr(aw_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q),
        .next_addr(w_next_addr), .word_idx(w_idx), .err(w_gen_err)
    );

    axi_burst_addr_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .IDX_W(IDX_W), .BASE_ADDR(MEM_BASE_ADDR)
    ) u_rd_gen (
        .addr(ar_addr_q), .len(ar_len_q), .size(ar_size_q), .burst(ar_burst_q),
        .next_addr(r_next_addr), .word_idx(r_idx), .err(r_gen_err)
    );

    assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

    assign bp_aw = BP_EN ? lfsr_q[0] : 1'b1;
    assign bp_w  = BP_EN ? lfsr_q[1] : 1'b1;
    assign bp_ar = BP_EN ? lfsr_q[2] : 1'b1;

    // Readies are also qualified by reset so they read 0 while reset is held
    assign S_AXI_AWREADY = S_AXI_ARESETN && (w_state_q == W_IDLE) && bp_aw;
    assign S_AXI_WREADY  = S_AXI_ARESETN && (w_state_q == W_DATA) && bp_w;
    assign S_AXI_ARREADY = S_AXI_ARESETN && (r_state_q == R_IDLE) && bp_ar;
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BID     = aw_id_q;
    assign S_AXI_BRESP   = w_err_q ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RID     = ar_id_q;
    assign S_AXI_RLAST   = (r_state_q == R_DATA) && (r_beat_q == ar_len_q);
    assign S_AXI_RRESP   = ((r_state_q == R_DATA) && r_gen_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RDATA   = ((r_state_q == R_DATA) && !r_gen_err) ? mem[r_idx] : '0;

    assign w_hs       = S_AXI_WVALID && S_AXI_WREADY;
    assign r_hs       = S_AXI_RVALID && S_AXI_RREADY;
    assign w_beat_err = w_gen_err || (S_AXI_WLAST != (w_beat_q == aw_len_q));

    // Burst length is tracked by beat count; WLAST only flags an error
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_beat_d   = w_beat_q;
        w_err_d    = w_err_q;
        case (w_state_q)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_id_d    = S_AXI_AWID;
                aw_addr_d  = S_AXI_AWADDR;
                aw_len_d   = S_AXI_AWLEN;
                aw_size_d  = S_AXI_AWSIZE;
                aw_burst_d = S_AXI_AWBURST;
                w_beat_d   = 8'd0;
                w_err_d    = 1'b0;
                w_state_d  = W_DATA;
            end
            W_DATA: if (w_hs) begin
                aw_addr_d = w_next_addr;
                w_beat_d  = w_beat_q + 8'd1;
                w_err_d   = w_err_q || w_beat_err;
                if (w_beat_q == aw_len_q) w_state_d = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_beat_d   = r_beat_q;
        r_wait_d   = r_wait_q;
        case (r_state_q)
            R_IDLE: if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                ar_id_d    = S_AXI_ARID;
                ar_addr_d  = S_AXI_ARADDR;
                ar_len_d   = S_AXI_ARLEN;
                ar_size_d  = S_AXI_ARSIZE;
                ar_burst_d = S_AXI_ARBURST;
                r_beat_d   = 8'd0;
                r_wait_d   = WAIT_LOAD;
                r_state_d  = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_wait_q == 4'd0) r_state_d = R_DATA;
                else                  r_wait_d  = r_wait_q - 4'd1;
            end
            R_DATA: if (r_hs) begin
                ar_addr_d = r_next_addr;
                r_beat_d  = r_beat_q + 8'd1;
                if (r_beat_q == ar_len_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_beat_q   <= '0;
            w_err_q    <= 1'b0;
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_beat_q   <= '0;
            r_wait_q   <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_beat_q   <= w_beat_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_beat_q   <= r_beat_d;
            r_wait_q   <= r_wait_d;
            lfsr_q     <= lfsr_d;
        end
    end

    // Storage has no reset; failing beats never reach it
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs && !w_beat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_full_mem_slave.sv
// Directed self-checking bench for axi_full_mem_slave with read latency 4,
// backpressure enabled and a 256-word memory.
module tb_axi_full_mem_slave;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam int          BUDGET = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, wlast, wvalid, bready, arvalid, rready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         awready, wready, bvalid, arready, rvalid, rlast;
    logic [3:0]   bid, rid;
    logic [1:0]   bresp, rresp;
    logic [127:0] rdata;

    int total = 0;
    int bad   = 0;

    logic [127:0] wr_data [16];
    logic [15:0]  wr_strb [16];
    logic [127:0] rd_data [16];
    logic [1:0]   rd_resp [16];
    logic         rd_last [16];
    logic [3:0]   rd_id   [16];

    always #5 clk = ~clk;

    axi_full_mem_slave #(
        .C_S_AXI_ID_WIDTH(4), .C_S_AXI_DATA_WIDTH(128), .C_S_AXI_ADDR_WIDTH(32),
        .MEM_BASE_ADDR(BASE), .MEM_DEPTH(256), .RD_LATENCY(4),
        .BP_EN(1'b1), .LFSR_SEED(16'hACE1)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0),
        .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0),
        .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    function automatic logic [127:0] beat_data(input int k);
        return {32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 ^ 32'(k * 7),
                32'h0F0F_0000 + 32'(k * 3), 32'(k)};
    endfunction

    // All handshake helpers start and end on a falling edge
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic hs = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < BUDGET && !hs; i++) begin
            hs = awready;
            @(negedge clk);
        end
        awvalid = 1'b0;
        if (!hs) begin total++; bad++; $display("[TB] FAIL aw_timeout: got no AWREADY want AWREADY"); end
    endtask

    task automatic w_send_beat(input logic [127:0] data, input logic [15:0] strb, input logic last);
        logic hs = 1'b0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int i = 0; i < BUDGET && !hs; i++) begin
            hs = wready;
            @(negedge clk);
        end
        wvalid = 1'b0;
        if (!hs) begin total++; bad++; $display("[TB] FAIL w_timeout: got no WREADY want WREADY"); end
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
        logic hs = 1'b0;
        resp = 2'bxx; id = 4'bxxxx; bready = 1'b1;
        for (int i = 0; i < BUDGET && !hs; i++) begin
            hs = bvalid;
            if (hs) begin resp = bresp; id = bid; end
            @(negedge clk);
        end
        bready = 1'b0;
        if (!hs) begin total++; bad++; $display("[TB] FAIL b_timeout: got no BVALID want BVALID"); end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input bit drop_last,
                               output logic [1:0] resp, output logic [3:0] id_out);
        aw_send(id, addr, len, 3'd4, burst);
        for (int k = 0; k <= int'(len); k++)
            w_send_beat(wr_data[k], wr_strb[k], (k == int'(len)) && !drop_last);
        b_recv(resp, id_out);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic hs = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < BUDGET && !hs; i++) begin
            hs = arready;
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (!hs) begin total++; bad++; $display("[TB] FAIL ar_timeout: got no ARREADY want ARREADY"); end
    endtask

    // RREADY toggles every cycle while beats are collected
    task automatic r_collect(input logic [7:0] len);
        int n = 0;
        for (int k = 0; k < 16; k++) begin
            rd_data[k] = 'x; rd_resp[k] = 'x; rd_last[k] = 1'bx; rd_id[k] = 'x;
        end
        rready = 1'b1;
        for (int i = 0; i < BUDGET && n <= int'(len); i++) begin
            if (rvalid && rready) begin
                rd_data[n] = rdata; rd_resp[n] = rresp; rd_last[n] = rlast; rd_id[n] = rid;
                n++;
            end
            @(negedge clk);
            rready = ~rready;
        end
        rready = 1'b0;
        if (n <= int'(len)) begin
            total++; bad++;
            $display("[TB] FAIL r_timeout: got %0d beats want %0d", n, int'(len) + 1);
        end
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        ar_send(id, addr, len, size, burst);
        r_collect(len);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_ctl: got %b want 000000", {awready, wready, arready, bvalid, rvalid, rlast});
        end
        total++; if (bresp !== 2'b00) begin bad++; $display("[TB] FAIL reset_bresp: got %b want 00", bresp); end
        total++; if (rresp !== 2'b00) begin bad++; $display("[TB] FAIL reset_rresp: got %b want 00", rresp); end
        total++; if (bid !== 4'h0) begin bad++; $display("[TB] FAIL reset_bid: got %h want 0", bid); end
        total++; if (rid !== 4'h0) begin bad++; $display("[TB] FAIL reset_rid: got %h want 0", rid); end
        total++; if (rdata !== 128'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_incr();
        logic [1:0] resp;
        logic [3:0] id;
        for (int k = 0; k < 16; k++) begin wr_data[k] = beat_data(k); wr_strb[k] = 16'hFFFF; end
        write_burst(4'h5, BASE, 8'd15, 2'b01, 1'b0, resp, id);
        total++; if (resp !== 2'b00) begin bad++; $display("[TB] FAIL incr_bresp: got %b want 00", resp); end
        total++; if (id !== 4'h5) begin bad++; $display("[TB] FAIL incr_bid: got %h want 5", id); end
        read_burst(4'h6, BASE, 8'd15, 3'd4, 2'b01);
        total++; if (rvalid !== 1'b0) begin bad++; $display("[TB] FAIL incr_rvalid_after: got %b want 0", rvalid); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (rd_data[k] !== beat_data(k)) begin
                bad++; $display("[TB] FAIL incr_data[%0d]: got %h want %h", k, rd_data[k], beat_data(k));
            end
            total++;
            if (rd_last[k] !== (k == 15)) begin
                bad++; $display("[TB] FAIL incr_rlast[%0d]: got %b want %b", k, rd_last[k], k == 15);
            end
            total++;
            if (rd_resp[k] !== 2'b00 || rd_id[k] !== 4'h6) begin
                bad++; $display("[TB] FAIL incr_resp_id[%0d]: got %b/%h want 00/6", k, rd_resp[k], rd_id[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [127:0] exp [4];
        exp[0] = beat_data(2); exp[1] = beat_data(3); exp[2] = beat_data(0); exp[3] = beat_data(1);
        read_burst(4'h2, BASE + 32'h20, 8'd3, 3'd4, 2'b10);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rd_data[k] !== exp[k] || rd_resp[k] !== 2'b00 || rd_last[k] !== (k == 3)) begin
                bad++; $display("[TB] FAIL wrap_beat[%0d]: got %h/%b/%b want %h/00/%b",
                                k, rd_data[k], rd_resp[k], rd_last[k], exp[k], k == 3);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [3:0] id;
        logic [127:0] exp;
        wr_data[0] = '1; wr_strb[0] = 16'hFFFF;
        write_burst(4'h1, BASE + 32'h100, 8'd0, 2'b01, 1'b0, resp, id);
        wr_data[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; wr_strb[0] = 16'h00FF;
        write_burst(4'h1, BASE + 32'h100, 8'd0, 2'b01, 1'b0, resp, id);
        total++; if (resp !== 2'b00) begin bad++; $display("[TB] FAIL strobe_bresp: got %b want 00", resp); end
        exp = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8899_AABB_CCDD_EEFF};
        read_burst(4'h1, BASE + 32'h100, 8'd0, 3'd4, 2'b01);
        total++; if (rd_data[0] !== exp) begin bad++; $display("[TB] FAIL strobe_data: got %h want %h", rd_data[0], exp); end
    endtask

    task automatic test_boundary();
        logic [1:0] resp;
        logic [3:0] id;
        wr_data[0] = beat_data(255); wr_strb[0] = 16'hFFFF;
        write_burst(4'h7, BASE + 32'hFF0, 8'd0, 2'b01, 1'b0, resp, id);
        total++; if (resp !== 2'b00) begin bad++; $display("[TB] FAIL top_word_bresp: got %b want 00", resp); end
        read_burst(4'h7, BASE + 32'hFF0, 8'd1, 3'd4, 2'b01);
        total++;
        if (rd_data[0] !== beat_data(255) || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL edge_beat0: got %h/%b/%b want %h/00/0", rd_data[0], rd_resp[0], rd_last[0], beat_data(255));
        end
        total++;
        if (rd_data[1] !== 128'h0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1) begin
            bad++; $display("[TB] FAIL edge_beat1: got %h/%b/%b want 0/10/1", rd_data[1], rd_resp[1], rd_last[1]);
        end
        write_burst(4'h7, BASE + 32'h1000, 8'd0, 2'b01, 1'b0, resp, id);
        total++; if (resp !== 2'b10) begin bad++; $display("[TB] FAIL above_range_bresp: got %b want 10", resp); end
        write_burst(4'h7, BASE - 32'h10, 8'd0, 2'b01, 1'b0, resp, id);
        total++; if (resp !== 2'b10) begin bad++; $display("[TB] FAIL below_base_bresp: got %b want 10", resp); end
        write_burst(4'h7, BASE + 32'h640, 8'd0, 2'b11, 1'b0, resp, id);
        total++; if (resp !== 2'b10) begin bad++; $display("[TB] FAIL rsvd_burst_bresp: got %b want 10", resp); end
        read_burst(4'h7, BASE, 8'd0, 3'd5, 2'b01);
        total++;
        if (rd_resp[0] !== 2'b10 || rd_data[0] !== 128'h0) begin
            bad++; $display("[TB] FAIL big_size_read: got %b/%h want 10/0", rd_resp[0], rd_data[0]);
        end
        read_burst(4'h7, BASE, 8'd2, 3'd4, 2'b10);
        total++;
        if (rd_resp[0] !== 2'b10 || rd_resp[2] !== 2'b10) begin
            bad++; $display("[TB] FAIL wrap_len2_read: got %b,%b want 10,10", rd_resp[0], rd_resp[2]);
        end
        // second beat carries a wrong WLAST and must be dropped
        wr_data[0] = beat_data(40); wr_data[1] = beat_data(41);
        wr_strb[0] = 16'hFFFF; wr_strb[1] = 16'hFFFF;
        write_burst(4'h8, BASE + 32'h280, 8'd1, 2'b01, 1'b0, resp, id);
        wr_data[0] = beat_data(50); wr_data[1] = beat_data(51);
        write_burst(4'h8, BASE + 32'h280, 8'd1, 2'b01, 1'b1, resp, id);
        total++; if (resp !== 2'b10) begin bad++; $display("[TB] FAIL wlast_bresp: got %b want 10", resp); end
        read_burst(4'h8, BASE + 32'h280, 8'd1, 3'd4, 2'b01);
        total++;
        if (rd_data[0] !== beat_data(50) || rd_data[1] !== beat_data(41)) begin
            bad++; $display("[TB] FAIL wlast_data: got %h,%h want %h,%h", rd_data[0], rd_data[1], beat_data(50), beat_data(41));
        end
    endtask

    task automatic test_latency();
        int lat = 1;
        ar_send(4'hA, BASE + 32'h10, 8'd0, 3'd4, 2'b01);
        while (!rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat != 5) begin bad++; $display("[TB] FAIL rd_latency: got %0d want 5", lat); end
        r_collect(8'd0);
        total++;
        if (rd_id[0] !== 4'hA || rd_data[0] !== beat_data(1) || rd_last[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL latency_beat: got %h/%h/%b want a/%h/1", rd_id[0], rd_data[0], rd_last[0], beat_data(1));
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] resp;
        logic [3:0] id;
        for (int k = 0; k < 16; k++) begin wr_data[k] = beat_data(100 + k); wr_strb[k] = 16'hFFFF; end
        write_burst(4'h3, BASE + 32'h400, 8'd15, 2'b01, 1'b0, resp, id);
        aw_send(4'h3, BASE + 32'h400, 8'd15, 3'd4, 2'b01);
        for (int k = 0; k < 6; k++) w_send_beat(beat_data(200 + k), 16'hFFFF, 1'b0);
        wdata = beat_data(206); wstrb = 16'hFFFF; wlast = 1'b0; wvalid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b0) begin
            bad++; $display("[TB] FAIL midreset_ctl: got %b want 000000", {awready, wready, arready, bvalid, rvalid, rlast});
        end
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_data[0] = beat_data(90); wr_strb[0] = 16'hFFFF;
        write_burst(4'h4, BASE + 32'h5A0, 8'd0, 2'b01, 1'b0, resp, id);
        total++;
        if (resp !== 2'b00 || id !== 4'h4) begin
            bad++; $display("[TB] FAIL post_reset_write: got %b/%h want 00/4", resp, id);
        end
        read_burst(4'h3, BASE + 32'h400, 8'd15, 3'd4, 2'b01);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (rd_data[k] !== beat_data(k < 6 ? 200 + k : 100 + k)) begin
                bad++; $display("[TB] FAIL midreset_data[%0d]: got %h want %h",
                                k, rd_data[k], beat_data(k < 6 ? 200 + k : 100 + k));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        test_reset();
        test_incr();
        test_wrap();
        test_strobe();
        test_boundary();
        test_latency();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
